// File: rtl/w_cond_pkg.sv
`default_nettype none
//------------------------------------------------------------------------------
// Module   : w_cond_pkg
// Brief    : Shared channel state encoding and defaults for the input conditioner.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
package w_cond_pkg;

    typedef enum logic [1:0] {
        STABLE_LO = 2'b00,
        CHECK_HI  = 2'b01,
        STABLE_HI = 2'b11,
        CHECK_LO  = 2'b10
    } chan_state_t;

    localparam int c_debounce_cycles = 16;

endpackage : w_cond_pkg
`default_nettype wire

// File: rtl/debounce_channel.sv
`default_nettype none
//------------------------------------------------------------------------------
// Module   : debounce_channel
// Brief    : Two-flop synchroniser followed by a stability-counting debounce FSM.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
module debounce_channel
    import w_cond_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = c_debounce_cycles,
    parameter int CNT_W           = 16
) (
    input  logic clk,
    input  logic reset,
    input  logic i_raw,
    output logic o_clean_nxt,
    output logic o_check_nxt
);

    localparam logic [CNT_W-1:0] c_cnt_one  = CNT_W'(1);
    localparam logic [CNT_W-1:0] c_cnt_last = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic              r_sync1;
    logic              r_sync2;
    chan_state_t       r_state;
    chan_state_t       w_state_nxt;
    logic [CNT_W-1:0]  r_cnt;
    logic [CNT_W-1:0]  w_cnt_nxt;
    logic              w_at_last;

    assign w_at_last = (r_cnt == c_cnt_last);

    // Any reversal while checking falls back to the previous stable level.
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = '0;
        case (r_state)
            STABLE_LO: begin
                if (r_sync2) begin
                    w_state_nxt = CHECK_HI;
                    w_cnt_nxt   = c_cnt_one;
                end
            end
            CHECK_HI: begin
                if (!r_sync2) begin
                    w_state_nxt = STABLE_LO;
                end else if (w_at_last) begin
                    w_state_nxt = STABLE_HI;
                end else begin
                    w_cnt_nxt   = r_cnt + c_cnt_one;
                end
            end
            STABLE_HI: begin
                if (!r_sync2) begin
                    w_state_nxt = CHECK_LO;
                    w_cnt_nxt   = c_cnt_one;
                end
            end
            CHECK_LO: begin
                if (r_sync2) begin
                    w_state_nxt = STABLE_HI;
                end else if (w_at_last) begin
                    w_state_nxt = STABLE_LO;
                end else begin
                    w_cnt_nxt   = r_cnt + c_cnt_one;
                end
            end
            default: begin
                w_state_nxt = STABLE_LO;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_sync1 <= 1'b0;
            r_sync2 <= 1'b0;
            r_state <= STABLE_LO;
            r_cnt   <= '0;
        end else begin
            r_sync1 <= i_raw;
            r_sync2 <= r_sync1;
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
        end
    end

    // Clean level is high in STABLE_HI and CHECK_LO, so it holds through checking.
    assign o_clean_nxt = (w_state_nxt == STABLE_HI) || (w_state_nxt == CHECK_LO);
    assign o_check_nxt = (w_state_nxt == CHECK_HI)  || (w_state_nxt == CHECK_LO);

endmodule : debounce_channel
`default_nettype wire

// File: rtl/w_input_conditioner.sv
`default_nettype none
//------------------------------------------------------------------------------
// Module   : w_input_conditioner
// Brief    : Debounces the data switch and turns the step button into a pulse.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
module w_input_conditioner
    import w_cond_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = c_debounce_cycles,
    parameter int CNT_W           = 16
) (
    input  logic clk,
    input  logic reset,
    input  logic raw_w,
    input  logic raw_step,
    output logic w,
    output logic step,
    output logic busy
);

    logic w_clean_w_nxt;
    logic w_check_w_nxt;
    logic w_clean_s_nxt;
    logic w_check_s_nxt;

    logic r_w;
    logic r_step_lvl;
    logic r_step;
    logic r_busy;

    debounce_channel #(
        .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
        .CNT_W           (CNT_W)
    ) u_chan_w (
        .clk         (clk),
        .reset       (reset),
        .i_raw       (raw_w),
        .o_clean_nxt (w_clean_w_nxt),
        .o_check_nxt (w_check_w_nxt)
    );

    debounce_channel #(
        .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
        .CNT_W           (CNT_W)
    ) u_chan_step (
        .clk         (clk),
        .reset       (reset),
        .i_raw       (raw_step),
        .o_clean_nxt (w_clean_s_nxt),
        .o_check_nxt (w_check_s_nxt)
    );

    // Outputs register the channels' next view so they line up with the FSM state.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_w        <= 1'b0;
            r_step_lvl <= 1'b0;
            r_step     <= 1'b0;
            r_busy     <= 1'b0;
        end else begin
            r_w        <= w_clean_w_nxt;
            r_step_lvl <= w_clean_s_nxt;
            r_step     <= w_clean_s_nxt & ~r_step_lvl;
            r_busy     <= w_check_w_nxt | w_check_s_nxt;
        end
    end

    assign w    = r_w;
    assign step = r_step;
    assign busy = r_busy;

endmodule : w_input_conditioner
`default_nettype wire

// File: tb/tb_w_input_conditioner.sv
`default_nettype none
//------------------------------------------------------------------------------
// Module   : tb_w_input_conditioner
// Brief    : Directed and random checks of the conditioner against a run-length model.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
module tb_w_input_conditioner;

    localparam int DB = 4;

    logic clk      = 1'b0;
    logic reset    = 1'b0;
    logic raw_w    = 1'b0;
    logic raw_step = 1'b0;
    logic w;
    logic step;
    logic busy;

    int tests  = 0;
    int fails  = 0;
    int npulse = 0;

    // Model: clean level flips once sync2 has disagreed with it DB times in a row.
    logic [1:0] ms1, ms2, mcl;
    int         mrun [2];
    logic       mstep;

    always #5 clk = ~clk;

    w_input_conditioner #(
        .DEBOUNCE_CYCLES (DB),
        .CNT_W           (4)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .raw_w    (raw_w),
        .raw_step (raw_step),
        .w        (w),
        .step     (step),
        .busy     (busy)
    );

    function automatic void model_clear();
        ms1     = '0;
        ms2     = '0;
        mcl     = '0;
        mrun[0] = 0;
        mrun[1] = 0;
        mstep   = 1'b0;
    endfunction

    task automatic chk(input string tag, input logic obs, input logic exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    task automatic chk_int(input string tag, input int obs, input int exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic check_all(input string tag);
        chk({tag, ".w"},    w,    mcl[0]);
        chk({tag, ".step"}, step, mstep);
        chk({tag, ".busy"}, busy, (mrun[0] != 0) || (mrun[1] != 0));
    endtask

    task automatic tick(input string tag);
        logic prev_s;
        @(posedge clk);
        if (reset) begin
            model_clear();
        end else begin
            prev_s = mcl[1];
            for (int i = 0; i < 2; i++) begin
                if (ms2[i] != mcl[i]) begin
                    mrun[i]++;
                    if (mrun[i] == DB) begin
                        mcl[i]  = ~mcl[i];
                        mrun[i] = 0;
                    end
                end else begin
                    mrun[i] = 0;
                end
            end
            ms2   = ms1;
            ms1   = {raw_step, raw_w};
            mstep = mcl[1] & ~prev_s;
        end
        #1;
        check_all(tag);
        if (step) npulse++;
    endtask

    task automatic async_reset(input string tag);
        reset = 1'b1;
        model_clear();
        #1;
        check_all({tag, ".async"});
        tick({tag, ".hold"});
        reset = 1'b0;
    endtask

    initial begin
        int wedge;
        int sedge;
        model_clear();

        // Reset with raw inputs toggling
        #1 reset = 1'b1;
        #1 check_all("rst.start");
        for (int i = 0; i < 4; i++) begin
            raw_w    = ~raw_w;
            raw_step = ~raw_step;
            tick("rst.held");
        end
        raw_w    = 1'b0;
        raw_step = 1'b0;
        reset    = 1'b0;
        tick("rst.after");
        chk("rst.after.w_c", w, 1'b0);
        for (int i = 0; i < 6; i++) tick("rst.settle");

        // Clean rise then symmetric fall
        raw_w = 1'b1;
        for (int e = 0; e < 8; e++) begin
            tick("rise");
            chk("rise.busy_c", busy, (e >= 2) && (e < DB + 1));
            chk("rise.w_c",    w,    e >= DB + 1);
        end
        raw_w = 1'b0;
        for (int e = 0; e < 8; e++) begin
            tick("fall");
            chk("fall.busy_c", busy, (e >= 2) && (e < DB + 1));
            chk("fall.w_c",    w,    e < DB + 1);
        end

        // Glitch shorter than the debounce window
        raw_w = 1'b1;
        for (int e = 0; e < 3; e++) begin
            tick("glitch.hi");
            chk("glitch.w_c", w, 1'b0);
        end
        raw_w = 1'b0;
        for (int e = 0; e < 8; e++) begin
            tick("glitch.lo");
            chk("glitch.w_c", w, 1'b0);
        end
        chk("glitch.busy_end", busy, 1'b0);

        // Bounce burst on the step button
        npulse = 0;
        sedge  = -1;
        for (int k = 0; k < 4; k++) begin
            raw_step = (k % 2 == 0);
            tick("bounce.burst");
        end
        raw_step = 1'b1;
        for (int e = 0; e < 10; e++) begin
            tick("bounce.hold");
            if (step && sedge < 0) sedge = e;
        end
        chk_int("bounce.pulse_edge", sedge, DB + 1);
        chk_int("bounce.pulses", npulse, 1);
        raw_step = 1'b0;
        for (int e = 0; e < 10; e++) tick("bounce.release");
        chk_int("bounce.pulses_after_release", npulse, 1);

        // Reset during CHECK_HI with the button still held
        raw_step = 1'b1;
        for (int e = 0; e < 3; e++) tick("rstmid.pre");
        chk("rstmid.busy_pre", busy, 1'b1);
        async_reset("rstmid");
        chk("rstmid.busy_post", busy, 1'b0);
        npulse = 0;
        sedge  = -1;
        for (int e = 0; e < 10; e++) begin
            tick("rstmid.rel");
            if (step && sedge < 0) sedge = e;
        end
        chk_int("rstmid.pulse_edge", sedge, DB + 1);
        chk_int("rstmid.pulses", npulse, 1);
        raw_step = 1'b0;
        for (int e = 0; e < 8; e++) tick("rstmid.settle");

        // Both channels rise together
        wedge    = -1;
        sedge    = -1;
        raw_w    = 1'b1;
        raw_step = 1'b1;
        for (int e = 0; e < 8; e++) begin
            tick("conc.rise");
            if (w && wedge < 0) wedge = e;
            if (step && sedge < 0) sedge = e;
        end
        chk_int("conc.w_edge",    wedge, DB + 1);
        chk_int("conc.step_edge", sedge, DB + 1);
        raw_w    = 1'b0;
        raw_step = 1'b0;
        for (int e = 0; e < 8; e++) tick("conc.fall");

        // Random bouncing inputs with occasional asynchronous resets
        for (int n = 0; n < 600; n++) begin
            if ($urandom_range(0, 99) == 0) begin
                async_reset("rand.rst");
            end else begin
                if ($urandom_range(0, 5) == 0) raw_w    = ~raw_w;
                if ($urandom_range(0, 5) == 0) raw_step = ~raw_step;
                tick("rand");
            end
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule : tb_w_input_conditioner
`default_nettype wire
